// File: rtl/msoc_oci_dct_pkg.sv
// Shared types and constants for the CPU2 OCI debug compressed trace (DCT) packer.
package msoc_oci_dct_pkg;

    localparam int unsigned ATOM_W             = 2;
    localparam int unsigned MAX_ATOMS          = 15;
    localparam int unsigned DCT_BUF_W          = 30;
    localparam int unsigned DCT_CNT_W          = 4;
    localparam int unsigned TIMEOUT_CYCLES_DEF = 64;

    typedef enum logic [1:0] {
        ACCUM = 2'd0,
        FLUSH = 2'd1,
        ENDED = 2'd2
    } dct_state_e;

    localparam logic [ATOM_W-1:0] ATOM_NOP   = 2'b00;
    localparam logic [ATOM_W-1:0] ATOM_EXEC  = 2'b01;
    localparam logic [ATOM_W-1:0] ATOM_NEXEC = 2'b10;
    localparam logic [ATOM_W-1:0] ATOM_WAYPT = 2'b11;

endpackage

// File: rtl/msoc_oci_dct_out_reg.sv
// Single-entry valid/ready holding register for completed DCT frames.
module msoc_oci_dct_out_reg
    import msoc_oci_dct_pkg::*;
(
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 load,
    input  logic [DCT_BUF_W-1:0] load_buffer,
    input  logic [DCT_CNT_W-1:0] load_count,
    input  logic                 frame_ready,
    output logic                 out_free,
    output logic                 frame_valid,
    output logic [DCT_BUF_W-1:0] frame_buffer,
    output logic [DCT_CNT_W-1:0] frame_count
);

    logic                 valid_q, valid_d;
    logic [DCT_BUF_W-1:0] buf_q, buf_d;
    logic [DCT_CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        valid_d = valid_q;
        buf_d   = buf_q;
        cnt_d   = cnt_q;
        if (load) begin
            valid_d = 1'b1;
            buf_d   = load_buffer;
            cnt_d   = load_count;
        end else if (frame_ready) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            valid_q <= 1'b0;
            buf_q   <= '0;
            cnt_q   <= '0;
        end else begin
            valid_q <= valid_d;
            buf_q   <= buf_d;
            cnt_q   <= cnt_d;
        end
    end

    assign out_free     = !valid_q || frame_ready;
    assign frame_valid  = valid_q;
    assign frame_buffer = buf_q;
    assign frame_count  = cnt_q;

endmodule

// File: rtl/msoc_cpu2_oci_dct_packer.sv
// Packs 2-bit trace atoms into 30-bit DCT frames and drives the end-of-trace flags.
// Optional idle auto-flush of partial frames: define MSOC_DCT_TIMEOUT_EN.
module msoc_cpu2_oci_dct_packer
    import msoc_oci_dct_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 atom_valid,
    input  logic [ATOM_W-1:0]    atom,
    output logic                 atom_ready,
    input  logic                 flush_req,
    output logic                 frame_valid,
    input  logic                 frame_ready,
    output logic [DCT_BUF_W-1:0] frame_buffer,
    output logic [DCT_CNT_W-1:0] frame_count,
    output logic [DCT_BUF_W-1:0] dct_buffer,
    output logic [DCT_CNT_W-1:0] dct_count,
    output logic                 test_ending,
    output logic                 test_has_ended
);

    if (TIMEOUT_CYCLES < 2 || ATOM_W * MAX_ATOMS != DCT_BUF_W || MAX_ATOMS > 15) begin : g_bad_cfg
        $error("msoc_cpu2_oci_dct_packer: invalid DCT configuration");
    end

    localparam logic [DCT_CNT_W-1:0] FULL_CNT = DCT_CNT_W'(MAX_ATOMS);

    dct_state_e           state_q, state_d;
    logic                 run_q;
    logic [DCT_BUF_W-1:0] buf_q, buf_d;
    logic [DCT_CNT_W-1:0] cnt_q, cnt_d;
    logic                 out_free;
    logic                 accept;
    logic                 load;

`ifdef MSOC_DCT_TIMEOUT_EN
    localparam int unsigned IDLE_W = $clog2(TIMEOUT_CYCLES);
    logic [IDLE_W-1:0] idle_q, idle_d;
    logic              timeout_hit;

    assign timeout_hit = (idle_q == IDLE_W'(TIMEOUT_CYCLES - 1));
`endif

    always_comb begin
        // run_q keeps atom_ready low until the first clock after reset release
        atom_ready = run_q && (state_q == ACCUM) && (cnt_q != FULL_CNT || out_free);
        accept     = atom_valid && atom_ready && !flush_req;
        load       = 1'b0;
        state_d    = state_q;

        case (state_q)
            ACCUM: begin
                load = (cnt_q == FULL_CNT) && out_free;
`ifdef MSOC_DCT_TIMEOUT_EN
                if (timeout_hit && cnt_q != '0 && out_free) begin
                    load = 1'b1;
                end
`endif
                if (flush_req) begin
                    state_d = FLUSH;
                end
            end
            FLUSH: begin
                load = (cnt_q != '0) && out_free;
                if (cnt_q == '0 && !frame_valid) begin
                    state_d = ENDED;
                end
            end
            default: ;
        endcase

        // Clearing on transfer first lets a same-cycle accept land in an empty buffer.
        buf_d = buf_q;
        cnt_d = cnt_q;
        if (load) begin
            buf_d = '0;
            cnt_d = '0;
        end
        if (accept) begin
            buf_d = {buf_d[DCT_BUF_W-ATOM_W-1:0], atom};
            cnt_d = cnt_d + DCT_CNT_W'(1);
        end

`ifdef MSOC_DCT_TIMEOUT_EN
        idle_d = idle_q;
        if (accept || load) begin
            idle_d = '0;
        end else if (state_q == ACCUM && cnt_q != '0 && !timeout_hit) begin
            idle_d = idle_q + IDLE_W'(1);
        end
`endif
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ACCUM;
            run_q   <= 1'b0;
            buf_q   <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            run_q   <= 1'b1;
            buf_q   <= buf_d;
            cnt_q   <= cnt_d;
        end
    end

`ifdef MSOC_DCT_TIMEOUT_EN
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            idle_q <= '0;
        end else begin
            idle_q <= idle_d;
        end
    end
`endif

    msoc_oci_dct_out_reg u_out_reg (
        .clk          (clk),
        .reset_n      (reset_n),
        .load         (load),
        .load_buffer  (buf_q),
        .load_count   (cnt_q),
        .frame_ready  (frame_ready),
        .out_free     (out_free),
        .frame_valid  (frame_valid),
        .frame_buffer (frame_buffer),
        .frame_count  (frame_count)
    );

    assign dct_buffer     = buf_q;
    assign dct_count      = cnt_q;
    assign test_ending    = (state_q != ACCUM);
    assign test_has_ended = (state_q == ENDED);

endmodule

// File: tb/tb_msoc_cpu2_oci_dct_packer.sv
// Self-checking bench for msoc_cpu2_oci_dct_packer against a queue-based reference model.
module tb_msoc_cpu2_oci_dct_packer;

    logic        clk         = 1'b0;
    logic        reset_n     = 1'b0;
    logic        atom_valid  = 1'b0;
    logic [1:0]  atom        = 2'b00;
    logic        flush_req   = 1'b0;
    logic        frame_ready = 1'b0;
    logic        atom_ready;
    logic        frame_valid;
    logic [29:0] frame_buffer;
    logic [3:0]  frame_count;
    logic [29:0] dct_buffer;
    logic [3:0]  dct_count;
    logic        test_ending;
    logic        test_has_ended;

    int checks = 0;
    int errors = 0;

    logic [1:0] stim[32];

    always #5 clk = ~clk;

    msoc_cpu2_oci_dct_packer dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .atom_valid     (atom_valid),
        .atom           (atom),
        .atom_ready     (atom_ready),
        .flush_req      (flush_req),
        .frame_valid    (frame_valid),
        .frame_ready    (frame_ready),
        .frame_buffer   (frame_buffer),
        .frame_count    (frame_count),
        .dct_buffer     (dct_buffer),
        .dct_count      (dct_count),
        .test_ending    (test_ending),
        .test_has_ended (test_has_ended)
    );

    // Reference model: atoms of the open frame in arrival order, one held output frame,
    // and the trace phase (0 accumulating, 1 flushing, 2 ended).
    int          m_q[$];
    bit          m_ov  = 1'b0;
    logic [29:0] m_ob  = '0;
    logic [3:0]  m_oc  = '0;
    int          m_ph  = 0;
    bit          m_run = 1'b0;

    function automatic logic [29:0] pack_q();
        logic [29:0] v = '0;
        foreach (m_q[i]) v = v * 4 + 30'(m_q[i]);
        return v;
    endfunction

    function automatic logic [29:0] pack_stim(input int first, input int n);
        logic [29:0] v = '0;
        for (int i = 0; i < n; i++) v = v * 4 + 30'(stim[first + i]);
        return v;
    endfunction

    function automatic bit exp_ready();
        return m_run && (m_ph == 0) && (m_q.size() != 15 || !m_ov || frame_ready);
    endfunction

    function automatic logic [71:0] exp_vec();
        return {exp_ready(), m_ov, m_ov ? m_ob : 30'd0, m_ov ? m_oc : 4'd0,
                pack_q(), 4'(m_q.size()), (m_ph != 0), (m_ph == 2)};
    endfunction

    logic [71:0] obs_vec;
    assign obs_vec = {atom_ready, frame_valid, frame_valid ? frame_buffer : 30'd0,
                      frame_valid ? frame_count : 4'd0, dct_buffer, dct_count,
                      test_ending, test_has_ended};

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            m_q.delete();
            m_ov  = 1'b0;
            m_ob  = '0;
            m_oc  = '0;
            m_ph  = 0;
            m_run = 1'b0;
        end else begin
            bit free, acc, ld;
            int n;
            n    = m_q.size();
            free = !m_ov || frame_ready;
            acc  = atom_valid && exp_ready() && !flush_req;
            ld   = (m_ph == 0 && n == 15 && free) || (m_ph == 1 && n > 0 && free);
            if (m_ph == 1 && n == 0 && !m_ov) m_ph = 2;
            else if (m_ph == 0 && flush_req) m_ph = 1;
            if (ld) begin
                m_ob = pack_q();
                m_oc = 4'(n);
                m_ov = 1'b1;
                m_q.delete();
            end else if (frame_ready) begin
                m_ov = 1'b0;
            end
            if (acc) m_q.push_back(int'(atom));
            m_run = 1'b1;
        end
    end

    task automatic drive(input logic v, input logic [1:0] a, input logic f, input logic r);
        @(negedge clk);
        atom_valid  = v;
        atom        = a;
        flush_req   = f;
        frame_ready = r;
        #1;
    endtask

    task automatic apply_reset();
        @(negedge clk);
        reset_n = 1'b0;
        atom_valid = 1'b0; atom = 2'b00; flush_req = 1'b0; frame_ready = 1'b0;
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        atom_valid = 1'b1; atom = 2'b11; frame_ready = 1'b1; flush_req = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if ({atom_ready, frame_valid, frame_buffer, frame_count, dct_buffer, dct_count,
             test_ending, test_has_ended} !== 72'd0) begin
            errors++;
            $display("FAIL reset_outputs: got %h want 0", {atom_ready, frame_valid, frame_buffer,
                     frame_count, dct_buffer, dct_count, test_ending, test_has_ended});
        end
        @(negedge clk);
        reset_n = 1'b1;
        atom_valid = 1'b0;
        #1;
        checks++;
        if (obs_vec !== exp_vec()) begin
            errors++;
            $display("FAIL reset_release: got %h want %h", obs_vec, exp_vec());
        end
    endtask

    task automatic test_full_frame();
        int sent = 0;
        int guard = 0;
        while (sent < 15 && guard < 100) begin
            drive(1'b1, 2'((sent % 3) + 1), 1'b0, 1'b1);
            checks++;
            if (obs_vec !== exp_vec()) begin
                errors++;
                $display("FAIL full_frame cyc %0d: got %h want %h", guard, obs_vec, exp_vec());
            end
            if (exp_ready()) sent++;
            guard++;
        end
        checks++;
        if (sent != 15) begin errors++; $display("FAIL full_frame_budget: got %0d want 15", sent); end
        repeat (2) begin
            drive(1'b0, 2'b00, 1'b0, 1'b0);
            checks++;
            if (obs_vec !== exp_vec()) begin
                errors++;
                $display("FAIL full_frame_hold: got %h want %h", obs_vec, exp_vec());
            end
        end
        checks++;
        if (frame_valid !== 1'b1 || frame_count !== 4'd15) begin
            errors++;
            $display("FAIL full_frame_count: got v=%b n=%0d want v=1 n=15", frame_valid, frame_count);
        end
        checks++;
        if (frame_buffer !== 30'h1B6DB6DB) begin
            errors++;
            $display("FAIL full_frame_buffer: got %h want 1b6db6db", frame_buffer);
        end
        checks++;
        if (dct_count !== 4'd0) begin
            errors++;
            $display("FAIL full_frame_dct_count: got %0d want 0", dct_count);
        end
        drive(1'b0, 2'b00, 1'b0, 1'b1);
        drive(1'b0, 2'b00, 1'b0, 1'b1);
        checks++;
        if (obs_vec !== exp_vec()) begin
            errors++;
            $display("FAIL full_frame_drain: got %h want %h", obs_vec, exp_vec());
        end
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 16; i++) stim[i] = 2'($urandom);
        for (int i = 0; i < 16; i++) begin
            drive(1'b1, stim[i], 1'b0, 1'b1);
            checks++;
            if (atom_ready !== 1'b1 || obs_vec !== exp_vec()) begin
                errors++;
                $display("FAIL back_to_back cyc %0d: got %h want %h", i, obs_vec, exp_vec());
            end
        end
        drive(1'b0, 2'b00, 1'b0, 1'b1);
        checks++;
        if (frame_valid !== 1'b1 || frame_count !== 4'd15 || frame_buffer !== pack_stim(0, 15)) begin
            errors++;
            $display("FAIL b2b_frame: got v=%b n=%0d buf=%h want v=1 n=15 buf=%h",
                     frame_valid, frame_count, frame_buffer, pack_stim(0, 15));
        end
        checks++;
        if (dct_count !== 4'd1 || dct_buffer !== 30'(stim[15])) begin
            errors++;
            $display("FAIL b2b_residue: got n=%0d buf=%h want n=1 buf=%h",
                     dct_count, dct_buffer, 30'(stim[15]));
        end
        drive(1'b0, 2'b00, 1'b0, 1'b1);
        checks++;
        if (obs_vec !== exp_vec()) begin
            errors++;
            $display("FAIL b2b_drain: got %h want %h", obs_vec, exp_vec());
        end
    endtask

    task automatic test_backpressure();
        int sent = 0;
        int guard = 0;
        apply_reset();
        for (int i = 0; i < 30; i++) stim[i] = 2'($urandom);
        while (sent < 30 && guard < 100) begin
            drive(1'b1, stim[sent], 1'b0, 1'b0);
            checks++;
            if (obs_vec !== exp_vec()) begin
                errors++;
                $display("FAIL backpressure cyc %0d: got %h want %h", guard, obs_vec, exp_vec());
            end
            if (exp_ready()) sent++;
            guard++;
        end
        checks++;
        if (sent != 30) begin errors++; $display("FAIL backpressure_budget: got %0d want 30", sent); end
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 2'($urandom), 1'b0, 1'b0);
            checks++;
            if (frame_valid !== 1'b1 || frame_count !== 4'd15 || frame_buffer !== pack_stim(0, 15)) begin
                errors++;
                $display("FAIL bp_hold cyc %0d: got v=%b n=%0d buf=%h want v=1 n=15 buf=%h",
                         i, frame_valid, frame_count, frame_buffer, pack_stim(0, 15));
            end
            checks++;
            if (atom_ready !== 1'b0 || dct_count !== 4'd15 || dct_buffer !== pack_stim(15, 15)) begin
                errors++;
                $display("FAIL bp_stall cyc %0d: got rdy=%b n=%0d buf=%h want rdy=0 n=15 buf=%h",
                         i, atom_ready, dct_count, dct_buffer, pack_stim(15, 15));
            end
        end
        drive(1'b0, 2'b00, 1'b0, 1'b1);
        checks++;
        if (atom_ready !== 1'b1) begin
            errors++;
            $display("FAIL bp_resume: got %b want 1", atom_ready);
        end
        drive(1'b0, 2'b00, 1'b0, 1'b0);
        checks++;
        if (frame_valid !== 1'b1 || frame_buffer !== pack_stim(15, 15) || dct_count !== 4'd0) begin
            errors++;
            $display("FAIL bp_second_frame: got v=%b buf=%h n=%0d want v=1 buf=%h n=0",
                     frame_valid, frame_buffer, dct_count, pack_stim(15, 15));
        end
        drive(1'b0, 2'b00, 1'b0, 1'b1);
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            drive($urandom_range(0, 9) < 7, 2'($urandom), 1'b0, $urandom_range(0, 9) < 6);
            checks++;
            if (obs_vec !== exp_vec()) begin
                errors++;
                $display("FAIL random cyc %0d: got %h want %h", i, obs_vec, exp_vec());
            end
        end
    endtask

    task automatic test_flush();
        int sent = 0;
        int guard = 0;
        apply_reset();
        for (int i = 0; i < 5; i++) stim[i] = 2'($urandom);
        while (sent < 5 && guard < 20) begin
            drive(1'b1, stim[sent], 1'b0, 1'b0);
            if (exp_ready()) sent++;
            guard++;
        end
        drive(1'b1, 2'b11, 1'b1, 1'b0);
        checks++;
        if (obs_vec !== exp_vec()) begin
            errors++;
            $display("FAIL flush_pulse: got %h want %h", obs_vec, exp_vec());
        end
        for (int i = 0; i < 4; i++) begin
            drive(1'b0, 2'b00, 1'b0, 1'b0);
            checks++;
            if (test_ending !== 1'b1 || test_has_ended !== 1'b0 || obs_vec !== exp_vec()) begin
                errors++;
                $display("FAIL flush_pending cyc %0d: got %h want %h", i, obs_vec, exp_vec());
            end
        end
        checks++;
        if (frame_valid !== 1'b1 || frame_count !== 4'd5 || frame_buffer !== pack_stim(0, 5)) begin
            errors++;
            $display("FAIL flush_frame: got v=%b n=%0d buf=%h want v=1 n=5 buf=%h",
                     frame_valid, frame_count, frame_buffer, pack_stim(0, 5));
        end
        guard = 0;
        while (test_has_ended !== 1'b1 && guard < 10) begin
            drive(1'b0, 2'b00, 1'b0, 1'b1);
            checks++;
            if (obs_vec !== exp_vec()) begin
                errors++;
                $display("FAIL flush_drain cyc %0d: got %h want %h", guard, obs_vec, exp_vec());
            end
            guard++;
        end
        checks++;
        if (test_has_ended !== 1'b1) begin
            errors++;
            $display("FAIL flush_end_timeout: got %b want 1", test_has_ended);
        end
        for (int i = 0; i < 12; i++) begin
            drive(1'b1, 2'($urandom), $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1);
            checks++;
            if (test_has_ended !== 1'b1 || test_ending !== 1'b1 || atom_ready !== 1'b0 ||
                dct_count !== 4'd0 || obs_vec !== exp_vec()) begin
                errors++;
                $display("FAIL ended_sticky cyc %0d: got %h want %h", i, obs_vec, exp_vec());
            end
        end
    endtask

    task automatic test_reset_midframe();
        int sent = 0;
        int guard = 0;
        apply_reset();
        while (sent < 22 && guard < 60) begin
            drive(1'b1, 2'($urandom), 1'b0, 1'b0);
            if (exp_ready()) sent++;
            guard++;
        end
        drive(1'b0, 2'b00, 1'b0, 1'b0);
        checks++;
        if (dct_count !== 4'd7 || frame_valid !== 1'b1) begin
            errors++;
            $display("FAIL midframe_setup: got n=%0d v=%b want n=7 v=1", dct_count, frame_valid);
        end
        @(posedge clk);
        #2 reset_n = 1'b0;
        #1;
        checks++;
        if ({atom_ready, frame_valid, frame_buffer, frame_count, dct_buffer, dct_count,
             test_ending, test_has_ended} !== 72'd0) begin
            errors++;
            $display("FAIL midframe_async_reset: got %h want 0", {atom_ready, frame_valid,
                     frame_buffer, frame_count, dct_buffer, dct_count, test_ending, test_has_ended});
        end
        @(negedge clk);
        reset_n = 1'b1;
        for (int i = 0; i < 60; i++) begin
            drive($urandom_range(0, 9) < 8, 2'($urandom), 1'b0, $urandom_range(0, 9) < 7);
            checks++;
            if (obs_vec !== exp_vec()) begin
                errors++;
                $display("FAIL after_reset cyc %0d: got %h want %h", i, obs_vec, exp_vec());
            end
        end
    endtask

    task automatic test_empty_flush();
        apply_reset();
        drive(1'b0, 2'b00, 1'b1, 1'b0);
        drive(1'b0, 2'b00, 1'b0, 1'b0);
        checks++;
        if (test_ending !== 1'b1 || test_has_ended !== 1'b0 || obs_vec !== exp_vec()) begin
            errors++;
            $display("FAIL empty_flush_enter: got %h want %h", obs_vec, exp_vec());
        end
        drive(1'b0, 2'b00, 1'b0, 1'b0);
        checks++;
        if (test_ending !== 1'b1 || test_has_ended !== 1'b1 || frame_valid !== 1'b0) begin
            errors++;
            $display("FAIL empty_flush_ended: got te=%b th=%b fv=%b want te=1 th=1 fv=0",
                     test_ending, test_has_ended, frame_valid);
        end
    endtask

    initial begin
        test_reset();
        test_full_frame();
        test_back_to_back();
        test_backpressure();
        test_random();
        test_flush();
        test_reset_midframe();
        test_empty_flush();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, checks=%0d errors=%0d", checks, errors);
        $fatal(1, "watchdog");
    end

endmodule
